fb_mem_target: RTL and testbench
================================

# fb_mem_target

Frame-buffer memory target on the video bus. It answers read and write bursts issued by a bus initiator such as the video controller's fetch engine, which drives `reqout`/`cmdout`/`lenout`/`addrdataout`/`reqtar` and receives `ackin`/`selin`. The block holds an internal word memory. It acknowledges each request, absorbs write data, and returns read data as a contiguous burst on the response channel.

## Interface
- `ADDR_W`, 10: word-address width; memory depth is 2^ADDR_W 32-bit words.
- `TARGET_ID`, 4'h1: value of `reqtar` this target responds to.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `reqin` input 2: request level from the initiator; any nonzero value is a request.
- `reqtar` input 4: target select; requests are honoured only when equal to `TARGET_ID`.
- `cmdin` input 3: command: 001 READ, 010 WRITE, 011 WDATA; other codes are illegal.
- `lenin` input 2: burst length: 00=1, 01=2, 10=4, 11=8 words.
- `addrdatain` input 32: byte address in the request cycle; write data in WDATA cycles.
- `ackout` output 1: one-cycle request acknowledge.
- `selout` output 1: response-channel valid.
- `cmdout` output 3: 100 RDATA while `selout` is high, else 000.
- `lenout` output 2: the `lenin` captured for the burst being returned.
- `addrdataout` output 32: read data word.
- `err` output 1: sticky flag set by an illegal command; cleared only by reset.

## Operation
- Word index is `addrdatain[ADDR_W+1:2]`. Bits [1:0] are ignored, and upper bits beyond ADDR_W+1 are ignored.
- Burst beat k uses index (base + k) mod 2^ADDR_W. Bursts wrap at the top of memory.
- FSM states: IDLE, ACK, WR, RD_WAIT, RD.
- **IDLE:** if `reqin != 0` and `reqtar == TARGET_ID`, capture cmd, len and base index, then go to ACK. Otherwise stay.
- **ACK:** `ackout` = 1 for this cycle only.
  - READ → RD_WAIT.
  - WRITE → WR.
  - Illegal cmd (including WDATA as a request) → set `err`, go to IDLE, no memory access.
- **WR:** each cycle with `cmdin == 011` writes `addrdatain` to the next index and increments the beat count. Cycles without WDATA are stalls: no write, no count.
  - After N writes → IDLE.
  - `reqin`/`reqtar` are ignored in WR.
- **RD_WAIT:** issue the synchronous memory read for beat 0 → RD.
- **RD:** `selout` = 1, `cmdout` = 100, `lenout` = captured len, `addrdataout` = beat data. Exactly N consecutive beats with no gaps. After the last beat → IDLE.
- Requests are never sampled outside IDLE. The initiator holds `reqin` until it sees `ackout`.
- Write data for a given index is visible to any read accepted after that write completes.
- Memory has no reset. Its contents survive `reset`.

## Timing
- Reset (`reset` = 0 at a rising edge): FSM → IDLE. Next cycle: `ackout`=0, `selout`=0, `cmdout`=000, `lenout`=00, `addrdataout`=0, `err`=0. Reset wins over any in-flight burst; a partially written burst keeps the words already written.
- Request sampled in cycle T → `ackout` high in T+1 only.
- Write: earliest WDATA beat is sampled in T+2. With no stalls the last beat is in T+1+N, and IDLE is reached at T+2+N.
- Read: `selout` is high for cycles T+3 through T+2+N. IDLE at T+3+N, so the earliest next request is sampled in T+3+N.
- All outputs are registered. Nothing in the block is combinational from input to output.
- A request and a reset in the same cycle: reset wins and no ack is issued.

## Test plan
- Reset, then `reqin`=01, `reqtar`=1, WRITE, len 10, addr 0x100; WDATA 0xA0..0xA3 in four consecutive cycles → single-cycle ack at T+1. Then READ len 10 at 0x100 → `selout` high 4 cycles starting 3 cycles after the request; data A0,A1,A2,A3; `cmdout`=100; `lenout`=10.
- Wrap: with ADDR_W=10, WRITE len 11 at byte 0xFF8 → words land at indices 1022,1023,0..5. A READ len 11 at 0 returns beats 2..7 of the write.
- Stall: WRITE len 01 with an idle cycle (`cmdin`=000) between beats → 2 words written, none corrupted, IDLE is reached one cycle later than unstalled.
- Target filter and illegal command: request with `reqtar`=2 → no ack for 20 cycles. Request with cmd 111 → ack then `err`=1, which holds until reset.
- Reset mid-read: assert `reset` during beat 2 of a len-11 read → next cycle all outputs are 0 and `err`=0. A subsequent READ still returns the previously written data.

Source files
------------

// File: rtl/fb_mem_target_if.sv
// Video-bus channel between an initiator and the frame-buffer memory target.
// Request side: level request, target select, command, burst length and a
// shared address/write-data bus. Response side: acknowledge plus a read-data
// channel carrying command, length and data.
interface fb_mem_target_if;
  logic [1:0]  reqin;
  logic [3:0]  reqtar;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackout;
  logic        selout;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;

  modport slave (
    input  reqin, reqtar, cmdin, lenin, addrdatain,
    output ackout, selout, cmdout, lenout, addrdataout
  );

  modport master (
    output reqin, reqtar, cmdin, lenin, addrdatain,
    input  ackout, selout, cmdout, lenout, addrdataout
  );
endinterface

// File: rtl/fb_mem_target.sv
// Frame-buffer memory target. Acknowledges read/write bursts addressed to
// TARGET_ID, absorbs write data beats (with stalls), and streams read data
// back as a gap-free burst. Burst addresses wrap at the top of memory.
// All outputs come straight from registers.
module fb_mem_target #(
  parameter int          ADDR_W    = 10,
  parameter logic [3:0]  TARGET_ID = 4'h1
) (
  input  logic           clk,
  input  logic           reset,
  fb_mem_target_if.slave bus,
  output logic           err
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_WDATA = 3'b011;
  localparam logic [2:0] CMD_RDATA = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    WR,
    RD_WAIT,
    RD
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cmd_q;
  logic [1:0]        len_q;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              sel_q, sel_d;
  logic              err_q, err_d;
  logic [2:0]        cmdout_q;
  logic [31:0]       rdata_q;

  logic              req_hit;
  logic              capture;
  logic              mem_we;
  logic              rd_en;
  logic [ADDR_W-1:0] mem_idx;
  logic [2:0]        last_beat;

  logic [31:0]       mem [DEPTH];

  assign req_hit = (bus.reqin != 2'b00) && (bus.reqtar == TARGET_ID);

  // Index of the final beat for the captured burst length (1, 2, 4 or 8 words).
  always_comb begin
    case (len_q)
      2'b00:   last_beat = 3'd0;
      2'b01:   last_beat = 3'd1;
      2'b10:   last_beat = 3'd3;
      default: last_beat = 3'd7;
    endcase
  end

  // Next-state logic, beat counting, memory strobes and next output values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    sel_d   = 1'b0;
    err_d   = err_q;
    capture = 1'b0;
    mem_we  = 1'b0;
    rd_en   = 1'b0;
    mem_idx = base_q + ADDR_W'(cnt_q);

    case (state_q)
      IDLE: begin
        if (req_hit) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          cnt_d   = 3'd0;
          state_d = ACK;
        end
      end

      ACK: begin
        case (cmd_q)
          CMD_READ:  state_d = RD_WAIT;
          CMD_WRITE: state_d = WR;
          default: begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        endcase
      end

      WR: begin
        // Cycles without WDATA are stalls: nothing is written or counted.
        if (bus.cmdin == CMD_WDATA) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == last_beat) state_d = IDLE;
        end
      end

      RD_WAIT: begin
        // Fetch beat 0 so it appears on the response channel next cycle.
        rd_en   = 1'b1;
        sel_d   = 1'b1;
        state_d = RD;
      end

      RD: begin
        // cnt_q is the beat currently presented; prefetch the following one.
        if (cnt_q == last_beat) begin
          state_d = IDLE;
        end else begin
          rd_en   = 1'b1;
          sel_d   = 1'b1;
          cnt_d   = cnt_q + 3'd1;
          mem_idx = base_q + ADDR_W'(cnt_q + 3'd1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, burst context and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q  <= IDLE;
      cmd_q    <= 3'b000;
      len_q    <= 2'b00;
      base_q   <= '0;
      cnt_q    <= 3'd0;
      ack_q    <= 1'b0;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
      cmdout_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      cmdout_q <= sel_d ? CMD_RDATA : 3'b000;
      if (capture) begin
        cmd_q  <= bus.cmdin;
        len_q  <= bus.lenin;
        base_q <= bus.addrdatain[ADDR_W+1:2];
      end
    end
  end

  // Word memory write port; reset suppresses a write in the reset cycle.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset; its contents must
    // survive reset and a reset loop would prevent RAM inference.
    if (mem_we && reset) mem[mem_idx] <= bus.addrdatain;
  end

  // Synchronous read port feeding the read-data output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= 32'h0;
    end else if (rd_en) begin
      rdata_q <= mem[mem_idx];
    end
  end

  assign bus.ackout      = ack_q;
  assign bus.selout      = sel_q;
  assign bus.cmdout      = cmdout_q;
  assign bus.lenout      = len_q;
  assign bus.addrdataout = rdata_q;
  assign err             = err_q;

endmodule

// File: tb/tb_fb_mem_target.sv
// Testbench for fb_mem_target: directed bursts (basic, wrap, stall, filter,
// illegal command, reset mid-read, reset with request) followed by random
// write/read-back bursts, checked against an array model of word memory.
module tb_fb_mem_target;

  localparam int         ADDR_W = 10;
  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] TID    = 4'h1;

  logic clk;
  logic reset;
  logic err;

  fb_mem_target_if bus ();

  fb_mem_target #(
    .ADDR_W    (ADDR_W),
    .TARGET_ID (TID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain word array plus a "has been written" flag.
  logic [31:0] model_mem   [DEPTH];
  bit          model_valid [DEPTH];
  logic [31:0] wbuf        [8];

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary line");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int word_idx(input logic [31:0] addr, input int k);
    return int'(((addr >> 2) + 32'(k)) & 32'(DEPTH - 1));
  endfunction

  task automatic idle_inputs();
    bus.reqin      = 2'b00;
    bus.reqtar     = 4'h0;
    bus.cmdin      = 3'b000;
    bus.lenin      = 2'b00;
    bus.addrdatain = 32'h0;
  endtask

  task automatic request(input logic [3:0] tar, input logic [2:0] cmd,
                         input logic [1:0] len, input logic [31:0] addr);
    bus.reqin      = 2'($urandom_range(1, 3));
    bus.reqtar     = tar;
    bus.cmdin      = cmd;
    bus.lenin      = len;
    bus.addrdatain = addr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},  32'(bus.ackout),  32'd0);
    check({tag, "_sel"},  32'(bus.selout),  32'd0);
    check({tag, "_cmd"},  32'(bus.cmdout),  32'd0);
    check({tag, "_len"},  32'(bus.lenout),  32'd0);
    check({tag, "_data"}, bus.addrdataout,  32'd0);
    check({tag, "_err"},  32'(err),         32'd0);
  endtask

  // Write burst from wbuf; one idle cycle is inserted before beat stall_at.
  task automatic do_write(input logic [31:0] addr, input logic [1:0] len, input int stall_at);
    int n;
    int k;
    int idx;
    bit stalled;
    n = 1 << len;
    k = 0;
    stalled = 1'b0;
    request(TID, 3'b010, len, addr);
    step();
    check("wr_ack", 32'(bus.ackout), 32'd1);
    idle_inputs();
    step();
    check("wr_ack_once", 32'(bus.ackout), 32'd0);
    while (k < n) begin
      if (k == stall_at && !stalled) begin
        bus.cmdin      = 3'b000;
        bus.addrdatain = $urandom;
        stalled        = 1'b1;
      end else begin
        bus.cmdin      = 3'b011;
        bus.addrdatain = wbuf[k];
        idx = word_idx(addr, k);
        model_mem[idx]   = wbuf[k];
        model_valid[idx] = 1'b1;
        k++;
      end
      step();
    end
    idle_inputs();
  endtask

  // Read burst; if abort_beat matches a beat, reset is pulsed during it.
  task automatic do_read(input logic [31:0] addr, input logic [1:0] len, input int abort_beat);
    int n;
    int idx;
    n = 1 << len;
    request(TID, 3'b001, len, addr);
    step();
    check("rd_ack", 32'(bus.ackout), 32'd1);
    check("rd_sel_early", 32'(bus.selout), 32'd0);
    idle_inputs();
    step();
    check("rd_ack_once", 32'(bus.ackout), 32'd0);
    check("rd_sel_wait", 32'(bus.selout), 32'd0);
    step();
    for (int k = 0; k < n; k++) begin
      idx = word_idx(addr, k);
      check($sformatf("rd_sel[%0d]", k), 32'(bus.selout), 32'd1);
      check($sformatf("rd_cmd[%0d]", k), 32'(bus.cmdout), 32'd4);
      check($sformatf("rd_len[%0d]", k), 32'(bus.lenout), 32'(len));
      if (model_valid[idx])
        check($sformatf("rd_data[%0d] idx %0d", k, idx), bus.addrdataout, model_mem[idx]);
      if (k == abort_beat) begin
        reset = 1'b0;
        step();
        check_reset_outputs("rst_mid_read");
        reset = 1'b1;
        return;
      end
      step();
    end
    check("rd_end_sel", 32'(bus.selout), 32'd0);
    check("rd_end_cmd", 32'(bus.cmdout), 32'd0);
  endtask

  initial begin
    int acks;
    int sels;
    logic [31:0] raddr;
    logic [1:0]  rlen;
    int          rstall;

    reset = 1'b0;
    idle_inputs();
    step();
    step();
    check_reset_outputs("por");
    reset = 1'b1;
    step();

    // Basic write of A0..A3 then read-back.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(32'h100, 2'b10, -1);
    do_read(32'h100, 2'b10, -1);

    // Wrap at the top of memory.
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    do_write(32'hFF8, 2'b11, -1);
    do_read(32'h0, 2'b11, -1);
    do_read(32'hFF8, 2'b11, -1);

    // Stall inside a 2-word write surrounded by known neighbours.
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    do_write(32'h200, 2'b10, -1);
    for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
    do_write(32'h204, 2'b01, 1);
    do_read(32'h200, 2'b10, -1);

    // Requests for another target are never acknowledged.
    request(4'h2, 3'b001, 2'b00, 32'h100);
    acks = 0;
    sels = 0;
    repeat (20) begin
      step();
      if (bus.ackout) acks++;
      if (bus.selout) sels++;
    end
    check("filter_acks", 32'(acks), 32'd0);
    check("filter_sels", 32'(sels), 32'd0);
    idle_inputs();
    step();

    // Illegal command: ack, then sticky err.
    request(TID, 3'b111, 2'b00, 32'h0);
    step();
    check("illegal_ack", 32'(bus.ackout), 32'd1);
    check("illegal_err_before", 32'(err), 32'd0);
    idle_inputs();
    step();
    check("illegal_err_set", 32'(err), 32'd1);
    check("illegal_ack_once", 32'(bus.ackout), 32'd0);
    repeat (5) step();
    check("illegal_err_hold", 32'(err), 32'd1);

    // WDATA used as a request is illegal too; no read data follows.
    request(TID, 3'b011, 2'b00, 32'h0);
    step();
    check("wdata_req_ack", 32'(bus.ackout), 32'd1);
    idle_inputs();
    step();
    check("wdata_req_err", 32'(err), 32'd1);
    check("wdata_req_sel", 32'(bus.selout), 32'd0);

    // Normal traffic still works with err set.
    do_read(32'h100, 2'b10, -1);
    check("err_sticky", 32'(err), 32'd1);

    // Reset during beat 2 of an 8-word read, then re-read.
    do_read(32'hFF8, 2'b11, 2);
    do_read(32'hFF8, 2'b11, -1);

    // Request in the same cycle as reset: reset wins, no ack.
    reset = 1'b0;
    request(TID, 3'b001, 2'b00, 32'h100);
    step();
    check("rst_req_ack", 32'(bus.ackout), 32'd0);
    reset = 1'b1;
    idle_inputs();
    step();
    check("rst_req_ack_after", 32'(bus.ackout), 32'd0);
    check("rst_req_sel_after", 32'(bus.selout), 32'd0);

    // Random bursts: write then read back, random length, address and stall.
    for (int it = 0; it < 12; it++) begin
      raddr  = $urandom;
      rlen   = 2'($urandom_range(0, 3));
      rstall = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      do_write(raddr, rlen, rstall);
      repeat ($urandom_range(0, 2)) step();
      do_read(raddr, rlen, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
